// File: rtl/btb_set_assoc.sv
// rtl/btb_set_assoc.sv - set-associative branch target buffer
// Combinational lookup, single-cycle update with 2-bit counters and per-set round-robin eviction.
module btb_set_assoc #(
   parameter int         SET_ADDR_LEN = 6,
   parameter int         WAYS         = 2,
   parameter logic [1:0] CNT_INIT     = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] rd_PC,
   output logic        rd_hit,
   output logic        rd_predicted,
   output logic [31:0] rd_predicted_PC,
   input  logic        upd_req,
   input  logic [31:0] upd_PC,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   localparam int SETS  = 1 << SET_ADDR_LEN;
   localparam int TAG_W = 30 - SET_ADDR_LEN;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [WAYS-1:0]  valid   [SETS];
   logic [TAG_W-1:0] tags    [SETS][WAYS];
   logic [31:0]      targets [SETS][WAYS];
   logic [1:0]       cnts    [SETS][WAYS];
   logic [WAY_W-1:0] rr_ptr  [SETS];

   logic [SET_ADDR_LEN-1:0] rd_set;
   logic [TAG_W-1:0]        rd_tag;
   logic [SET_ADDR_LEN-1:0] upd_set;
   logic [TAG_W-1:0]        upd_tag;

   assign rd_set  = rd_PC[SET_ADDR_LEN+1:2];
   assign rd_tag  = rd_PC[31:SET_ADDR_LEN+2];
   assign upd_set = upd_PC[SET_ADDR_LEN+1:2];
   assign upd_tag = upd_PC[31:SET_ADDR_LEN+2];

   logic unused_pc_low_bits;
   assign unused_pc_low_bits = ^{rd_PC[1:0], upd_PC[1:0]};

   // Lookup: descending scan so the lowest matching way wins.
   logic             rd_any;
   logic [WAY_W-1:0] rd_way;

   always_comb begin
      rd_any = 1'b0;
      rd_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[rd_set][w] && (tags[rd_set][w] == rd_tag)) begin
            rd_any = 1'b1;
            rd_way = WAY_W'(w);
         end
      end
   end

   assign rd_hit          = rd_any;
   assign rd_predicted    = rd_any & cnts[rd_set][rd_way][1];
   assign rd_predicted_PC = rd_any ? targets[rd_set][rd_way] : 32'h0;

   logic             upd_hit;
   logic [WAY_W-1:0] upd_way;
   logic             free_any;
   logic [WAY_W-1:0] free_way;
   logic [WAY_W-1:0] victim;
   logic [1:0]       cnt_cur;
   logic [1:0]       cnt_next;

   always_comb begin
      upd_hit  = 1'b0;
      upd_way  = '0;
      free_any = 1'b0;
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[upd_set][w] && (tags[upd_set][w] == upd_tag)) begin
            upd_hit = 1'b1;
            upd_way = WAY_W'(w);
         end
         if (!valid[upd_set][w]) begin
            free_any = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      victim = '0;
      if (free_any)
         victim = free_way;
      else if (WAYS > 1)
         victim = rr_ptr[upd_set];
   end

   assign cnt_cur = cnts[upd_set][upd_way];

   always_comb begin
      cnt_next = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != 2'b11)
            cnt_next = cnt_cur + 2'b01;
      end else begin
         if (cnt_cur != 2'b00)
            cnt_next = cnt_cur - 2'b01;
      end
   end

   // Flush has priority over any update presented in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s]  <= '0;
            rr_ptr[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tags[s][w]    <= '0;
               targets[s][w] <= '0;
               cnts[s][w]    <= '0;
            end
         end
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s]  <= '0;
            rr_ptr[s] <= '0;
         end
      end else if (upd_req) begin
         if (upd_hit) begin
            cnts[upd_set][upd_way] <= cnt_next;
            if (upd_taken)
               targets[upd_set][upd_way] <= upd_target;
         end else if (upd_taken) begin
            valid[upd_set][victim]   <= 1'b1;
            tags[upd_set][victim]    <= upd_tag;
            targets[upd_set][victim] <= upd_target;
            cnts[upd_set][victim]    <= CNT_INIT;
            // The pointer only moves when a live entry was evicted.
            if ((WAYS > 1) && !free_any)
               rr_ptr[upd_set] <= rr_ptr[upd_set] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_btb_set_assoc.sv
// tb/tb_btb_set_assoc.sv - scoreboard bench for btb_set_assoc
// Directed vectors push expected lookups; a negedge monitor pops and compares.
module tb_btb_set_assoc;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] rd_PC;
   logic        rd_hit;
   logic        rd_predicted;
   logic [31:0] rd_predicted_PC;
   logic        upd_req;
   logic [31:0] upd_PC;
   logic        upd_taken;
   logic [31:0] upd_target;

   btb_set_assoc #(.SET_ADDR_LEN(6), .WAYS(2), .CNT_INIT(2'b10)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .rd_PC           (rd_PC),
      .rd_hit          (rd_hit),
      .rd_predicted    (rd_predicted),
      .rd_predicted_PC (rd_predicted_PC),
      .upd_req         (upd_req),
      .upd_PC          (upd_PC),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target)
   );

   typedef struct {
      int          step;
      logic        hit;
      logic        pred;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   logic chk;
   int   step;
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step %0d", step);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (rd_hit !== e.hit) begin
               errors++;
               $display("FAIL rd_hit step %0d got %b want %b", e.step, rd_hit, e.hit);
            end
            checks++;
            if (rd_predicted !== e.pred) begin
               errors++;
               $display("FAIL rd_predicted step %0d got %b want %b", e.step, rd_predicted, e.pred);
            end
            checks++;
            if (rd_predicted_PC !== e.pc) begin
               errors++;
               $display("FAIL rd_predicted_PC step %0d got %h want %h", e.step, rd_predicted_PC, e.pc);
            end
         end
      end
   end

   // One cycle: drive inputs, queue the expected lookup, advance to the next edge.
   task automatic cyc(input logic r, input logic f, input logic u, input logic [31:0] upc,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] rpc,
                      input logic eh, input logic ep, input logic [31:0] epc);
      exp_t e;
      rst        = r;
      flush      = f;
      upd_req    = u;
      upd_PC     = upc;
      upd_taken  = tk;
      upd_target = tgt;
      rd_PC      = rpc;
      e.step = step;
      e.hit  = eh;
      e.pred = ep;
      e.pc   = epc;
      exp_q.push_back(e);
      chk = 1'b1;
      @(posedge clk);
      #1;
      step++;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      step   = 0;
      chk    = 1'b0;
      rst    = 1'b1;
      flush  = 1'b0;
      upd_req = 1'b0;
      upd_PC = '0;
      upd_taken = 1'b0;
      upd_target = '0;
      rd_PC = '0;
      @(posedge clk);
      #1;
      //  rst  fl   upd  upd_PC        tk   target        rd_PC         hit  pred pc
      cyc(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b0,1'b0,32'h0);
      // allocate, no same-cycle bypass
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b1,32'h0000_2000,32'h0000_1000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b1,1'b1,32'h0000_2000);
      // not-taken x2: counter 2 -> 1 -> 0
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b0,32'hDEAD_0000,32'h0000_1000,1'b1,1'b1,32'h0000_2000);
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b0,32'hDEAD_0000,32'h0000_1000,1'b1,1'b0,32'h0000_2000);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b1,1'b0,32'h0000_2000);
      // taken x4: 0 -> 1 -> 2 -> 3 -> 3, last one retargets
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b1,32'h0000_2000,32'h0000_1000,1'b1,1'b0,32'h0000_2000);
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b1,32'h0000_2000,32'h0000_1000,1'b1,1'b0,32'h0000_2000);
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b1,32'h0000_2000,32'h0000_1000,1'b1,1'b1,32'h0000_2000);
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b1,32'h0000_2222,32'h0000_1000,1'b1,1'b1,32'h0000_2000);
      // saturated at 3: one not-taken leaves it predicting taken
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b0,32'h0,        32'h0000_1000,1'b1,1'b1,32'h0000_2222);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b1,1'b1,32'h0000_2222);
      // set 0 aliases: fill way 1, then evict way 0, then way 1
      cyc(1'b0,1'b0,1'b1,32'h0000_2000,1'b1,32'h0000_A000,32'h0000_2000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b1,32'h0000_3000,1'b1,32'h0000_B000,32'h0000_2000,1'b1,1'b1,32'h0000_A000);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_3000,1'b1,1'b1,32'h0000_B000);
      cyc(1'b0,1'b0,1'b1,32'h0000_4000,1'b1,32'h0000_C000,32'h0000_2000,1'b1,1'b1,32'h0000_A000);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_2000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_4000,1'b1,1'b1,32'h0000_C000);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_3000,1'b1,1'b1,32'h0000_B000);
      // not-taken miss allocates nothing
      cyc(1'b0,1'b0,1'b1,32'h0000_5000,1'b0,32'h0000_E000,32'h0000_5000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_5000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_4000,1'b1,1'b1,32'h0000_C000);
      // flush beats a same-cycle taken update
      cyc(1'b0,1'b1,1'b1,32'h0000_6000,1'b1,32'h0000_D000,32'h0000_4000,1'b1,1'b1,32'h0000_C000);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_6000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_3000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_4000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b1,32'h0000_1000,1'b1,32'h0000_2000,32'h0000_1000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b1,1'b1,32'h0000_2000);
      // async reset mid-sequence clears outputs at once and aborts the update
      cyc(1'b1,1'b0,1'b1,32'h0000_7000,1'b1,32'h0000_F000,32'h0000_1000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_7000,1'b0,1'b0,32'h0);
      // another set, low PC bits ignored
      cyc(1'b0,1'b0,1'b1,32'h0000_1004,1'b1,32'h0000_0055,32'h0000_1004,1'b0,1'b0,32'h0);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1004,1'b1,1'b1,32'h0000_0055);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1007,1'b1,1'b1,32'h0000_0055);
      cyc(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1000,1'b0,1'b0,32'h0);
      chk = 1'b0;
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog step %0d", step);
      $fatal(1);
   end

endmodule
